// File: rtl/pc_seq_pkg.sv
// Shared encodings for the RV32I multi-cycle sequencer: states, opcodes,
// PC-select and writeback-select codes, plus opcode decode helpers.
package pc_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_TRAP   = 3'd6
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_OP     = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [1:0] PCSEL_PCADD4 = 2'b00;
   localparam logic [1:0] PCSEL_IMMGEN = 2'b01;
   localparam logic [1:0] PCSEL_ALU    = 2'b10;

   localparam logic [1:0] WB_ALU = 2'b00;
   localparam logic [1:0] WB_MEM = 2'b01;
   localparam logic [1:0] WB_PC4 = 2'b10;
   localparam logic [1:0] WB_IMM = 2'b11;

   function automatic logic is_legal(input logic [6:0] op);
      case (op)
         OP_LOAD, OP_STORE, OP_OP, OP_IMM, OP_LUI,
         OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH: is_legal = 1'b1;
         default:                              is_legal = 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] wb_sel_of(input logic [6:0] op);
      case (op)
         OP_LOAD:          wb_sel_of = WB_MEM;
         OP_JAL, OP_JALR:  wb_sel_of = WB_PC4;
         OP_LUI:           wb_sel_of = WB_IMM;
         default:          wb_sel_of = WB_ALU;
      endcase
   endfunction

   // PC source used when an instruction retires from the WB state
   function automatic logic [1:0] wb_pc_sel_of(input logic [6:0] op);
      case (op)
         OP_JAL:  wb_pc_sel_of = PCSEL_IMMGEN;
         OP_JALR: wb_pc_sel_of = PCSEL_ALU;
         default: wb_pc_sel_of = PCSEL_PCADD4;
      endcase
   endfunction

endpackage

// File: rtl/pc_seq_if.sv
// Instruction- and data-memory request/acknowledge handshake of the sequencer.
interface pc_seq_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_we;
   logic dmem_ack;

   modport master (
      output imem_req, dmem_req, dmem_we,
      input  imem_ack, dmem_ack
   );

   modport slave (
      input  imem_req, dmem_req, dmem_we,
      output imem_ack, dmem_ack
   );
endinterface

// File: rtl/pc_sequencer_wait_timer.sv
// Bounded-wait counter: flags expiry on the cycle the TIMEOUT-th consecutive
// unacknowledged request cycle is seen. TIMEOUT = 0 never expires.
module wait_timer #(
   parameter int TIMEOUT = 15
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic waiting,
   input  logic ack,
   output logic expired
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   logic [CW-1:0] count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (waiting && !ack)
         count <= count + CW'(1);
   end

   // An ack on the limit cycle suppresses expiry
   assign expired = (TIMEOUT > 0) && waiting && !ack && (count == LAST);

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle control FSM for the RV32I core: fetch/decode/exec/mem/wb
// sequencing, PC update strobes, retire counting and sticky trap.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int DWIDTH  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run,
   input  logic [6:0]        opcode,
   input  logic              comparator,
   pc_seq_if.master          mem,
   output logic              ir_load,
   output logic              pc_en,
   output logic [1:0]        pc_select,
   output logic              rf_we,
   output logic [1:0]        wb_sel,
   output logic [2:0]        state_o,
   output logic              trap,
   output logic [DWIDTH-1:0] instret
);

   state_t     state;
   state_t     nxt;
   logic [6:0] op_q;
   logic       imem_req_c;
   logic       dmem_req_c;
   logic       dmem_we_c;
   logic       retire;
   logic       tmr_waiting;
   logic       tmr_ack;
   logic       tmr_expired;

   // Timer inputs come straight from the state so expiry never loops back
   // through the output decode.
   assign tmr_waiting = (state == S_FETCH) || (state == S_MEM);
   assign tmr_ack     = (state == S_FETCH) ? mem.imem_ack : mem.dmem_ack;

   wait_timer #(
      .TIMEOUT (TIMEOUT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (!tmr_waiting),
      .waiting (tmr_waiting),
      .ack     (tmr_ack),
      .expired (tmr_expired)
   );

   always_comb begin
      nxt        = state;
      imem_req_c = 1'b0;
      dmem_req_c = 1'b0;
      dmem_we_c  = 1'b0;
      ir_load    = 1'b0;
      retire     = 1'b0;
      pc_select  = PCSEL_PCADD4;
      rf_we      = 1'b0;
      wb_sel     = WB_ALU;
      trap       = 1'b0;
      case (state)
         S_IDLE: begin
            if (run)
               nxt = S_FETCH;
         end
         S_FETCH: begin
            imem_req_c = 1'b1;
            if (mem.imem_ack) begin
               ir_load = 1'b1;
               nxt     = S_DECODE;
            end else if (tmr_expired) begin
               nxt = S_TRAP;
            end
         end
         S_DECODE: begin
            nxt = is_legal(opcode) ? S_EXEC : S_TRAP;
         end
         S_EXEC: begin
            if (op_q == OP_LOAD || op_q == OP_STORE) begin
               nxt = S_MEM;
            end else if (op_q == OP_BRANCH) begin
               retire    = 1'b1;
               pc_select = comparator ? PCSEL_IMMGEN : PCSEL_PCADD4;
            end else begin
               nxt = S_WB;
            end
         end
         S_MEM: begin
            dmem_req_c = 1'b1;
            dmem_we_c  = (op_q == OP_STORE);
            if (mem.dmem_ack) begin
               if (op_q == OP_STORE)
                  retire = 1'b1;
               else
                  nxt = S_WB;
            end else if (tmr_expired) begin
               nxt = S_TRAP;
            end
         end
         S_WB: begin
            rf_we     = 1'b1;
            wb_sel    = wb_sel_of(op_q);
            pc_select = wb_pc_sel_of(op_q);
            retire    = 1'b1;
         end
         S_TRAP: begin
            trap = 1'b1;
         end
         default: begin
            nxt = S_IDLE;
         end
      endcase
      pc_en = retire;
      // run only gates the start of the next instruction
      if (retire)
         nxt = run ? S_FETCH : S_IDLE;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         instret <= '0;
      end else begin
         state <= nxt;
         if (retire)
            instret <= instret + DWIDTH'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_DECODE)
         op_q <= opcode;
   end

   assign mem.imem_req = imem_req_c;
   assign mem.dmem_req = dmem_req_c;
   assign mem.dmem_we  = dmem_we_c;
   assign state_o      = state;

endmodule
